// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared widths, word limit and FSM encoding for the sprite memory paths
// Contents: ELEMENT_BITS, ADDR_BITS, DATA_BITS, SPRITE_WORDS, sprite_state_t
package sprite_pkg;

  localparam int ELEMENT_BITS = 3;
  localparam int ADDR_BITS    = 10;
  localparam int DATA_BITS    = 12;   // 4 bits each of R, G, B
  localparam int SPRITE_WORDS = 400;  // one 20x20 sprite

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } sprite_state_t;

endpackage

// File: rtl/sprite_addr_counter.sv
// rtl/sprite_addr_counter.sv - loadable word index with terminal flag and wrapped base+index address
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   load               capture load_base/load_length and clear the index
//   step               advance the index by one word
//   load_base          first word address
//   load_length        number of words (already clamped by the caller)
//   address            (base + index) mod 2^ADDR_BITS
//   last               index is the final word of the command
module sprite_addr_counter
  import sprite_pkg::*;
#(
  parameter int AW = sprite_pkg::ADDR_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] load_base,
  input  logic [AW-1:0] load_length,
  output logic [AW-1:0] address,
  output logic          last
);

  logic [AW-1:0] base_q;
  logic [AW-1:0] length_q;
  logic [AW-1:0] index_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      length_q <= '0;
      index_q  <= '0;
    end else if (load) begin
      base_q   <= load_base;
      length_q <= load_length;
      index_q  <= '0;
    end else if (step) begin
      index_q  <= index_q + AW'(1);
    end
  end

  // Truncation to AW bits gives the wrap past the top of memory for free.
  assign address = base_q + index_q;
  assign last    = (index_q == length_q - AW'(1));

endmodule

// File: rtl/sprite_mem_writer.sv
// rtl/sprite_mem_writer.sv - loads a pixel stream into sprite memory, stalled during active video
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready                 load command handshake
//   cmd_element, cmd_base, cmd_length   target element, first address, word count
//   pix_valid/pix_ready, pix_data       pixel word handshake and data
//   video_enable                        display active-area flag
//   mem_write_enable, mem_element,
//   mem_address, mem_datain             registered sprite memory write port
//   busy                                command in progress
//   done                                one-cycle completion pulse
module sprite_mem_writer #(
  parameter int ELEMENT_BITS = sprite_pkg::ELEMENT_BITS,
  parameter int ADDR_BITS    = sprite_pkg::ADDR_BITS,
  parameter int DATA_BITS    = sprite_pkg::DATA_BITS,
  parameter int SPRITE_WORDS = sprite_pkg::SPRITE_WORDS,
  parameter bit BLANK_ONLY   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ELEMENT_BITS-1:0] cmd_element,
  input  logic [ADDR_BITS-1:0]    cmd_base,
  input  logic [ADDR_BITS-1:0]    cmd_length,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [DATA_BITS-1:0]    pix_data,
  input  logic                    video_enable,
  output logic                    mem_write_enable,
  output logic [ELEMENT_BITS-1:0] mem_element,
  output logic [ADDR_BITS-1:0]    mem_address,
  output logic [DATA_BITS-1:0]    mem_datain,
  output logic                    busy,
  output logic                    done
);

  import sprite_pkg::*;

  localparam logic [ADDR_BITS-1:0] MAX_LEN = ADDR_BITS'(SPRITE_WORDS);

  sprite_state_t         state_q, state_d;
  logic                  cmd_take;
  logic                  pix_take;
  logic                  last_word;
  logic [ADDR_BITS-1:0]  word_address;
  logic [ADDR_BITS-1:0]  length_clamped;

  assign length_clamped = (cmd_length > MAX_LEN) ? MAX_LEN : cmd_length;

  sprite_addr_counter #(
    .AW(ADDR_BITS)
  ) u_addr_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cmd_take),
    .step       (pix_take),
    .load_base  (cmd_base),
    .load_length(length_clamped),
    .address    (word_address),
    .last       (last_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    pix_ready = 1'b0;
    cmd_take  = 1'b0;
    pix_take  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted so every output reads 0 in reset.
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
          cmd_take = 1'b1;
          state_d  = (cmd_length == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The memory has one port; the display owns it during active video.
        pix_ready = !(BLANK_ONLY && video_enable);
        pix_take  = pix_valid && pix_ready;
        if (pix_take && last_word) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write_enable <= 1'b0;
      mem_element      <= '0;
      mem_address      <= '0;
      mem_datain       <= '0;
    end else begin
      mem_write_enable <= pix_take;
      if (cmd_take) mem_element <= cmd_element;
      if (pix_take) begin
        mem_address <= word_address;
        mem_datain  <= pix_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mem_writer.sv
// tb/tb_sprite_mem_writer.sv - randomized self-checking bench for sprite_mem_writer
module tb_sprite_mem_writer;

  localparam int MAXW = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_element = '0;
  logic [9:0]  cmd_base = '0;
  logic [9:0]  cmd_length = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [11:0] pix_data = '0;
  logic        video_enable = 1'b0;
  logic        mem_write_enable;
  logic [2:0]  mem_element;
  logic [9:0]  mem_address;
  logic [11:0] mem_datain;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cmd_cyc = 0;

  logic [24:0] wr_q[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  logic [24:0] exp_q[$];
  logic [11:0] data_q[$];

  sprite_mem_writer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_element(cmd_element), .cmd_base(cmd_base), .cmd_length(cmd_length),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .video_enable(video_enable),
    .mem_write_enable(mem_write_enable), .mem_element(mem_element),
    .mem_address(mem_address), .mem_datain(mem_datain),
    .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write_enable) begin
      wr_q.push_back({mem_element, mem_address, mem_datain});
      wr_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic clear_mon();
    wr_q.delete();
    wr_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic make_data(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(12'($urandom));
  endtask

  // Reference: words = min(len, 400), address i = (base + i) mod 1024.
  task automatic build_exp(input logic [2:0] el, input logic [9:0] base, input int len);
    int n;
    logic [9:0] a;
    exp_q.delete();
    n = (len > MAXW) ? MAXW : len;
    for (int i = 0; i < n; i++) begin
      a = 10'((int'(base) + i) % 1024);
      exp_q.push_back({el, a, data_q[i]});
    end
  endtask

  task automatic issue_cmd(input logic [2:0] el, input logic [9:0] base, input logic [9:0] len);
    int guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_element = el;
    cmd_base    = base;
    cmd_length  = len;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_cyc   = cyc;
  endtask

  task automatic drive_pixels(input int start, input int n, input bit rnd);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 5000) begin
      pix_valid    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      video_enable = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
      pix_data     = data_q[start + sent];
      #1;
      if (pix_valid && pix_ready) sent++;
      @(negedge clk);
      guard++;
    end
    pix_valid    = 1'b0;
    video_enable = 1'b0;
    if (sent < n) begin
      tests++;
      fails++;
      $display("FAIL pixel_timeout: sent %0d words, required %0d", sent, n);
    end
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    #1;
    while (done_cyc.size() == 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    tests++;
    if (done_cyc.size() != 1) begin
      fails++;
      $display("FAIL %s_done: got %0d done pulses, required 1", name, done_cyc.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({cmd_ready, pix_ready, mem_write_enable, busy, done, mem_element, mem_address, mem_datain} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {cmd_ready, pix_ready, mem_write_enable, busy, done, mem_element, mem_address, mem_datain});
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release: cmd_ready/busy=%b required 10", {cmd_ready, busy});
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_mon();
    data_q = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
    build_exp(3'd2, 10'd0, 4);
    issue_cmd(3'd2, 10'd0, 10'd4);
    #1;
    tests++;
    if ({busy, cmd_ready} !== 2'b10) begin
      fails++;
      $display("FAIL basic_busy: busy/cmd_ready=%b required 10", {busy, cmd_ready});
    end
    drive_pixels(0, 4, 1'b0);
    wait_done("basic");
    tests++;
    if (wr_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL basic_count: got %0d writes, required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (wr_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL basic_write[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
        end
      end
      tests++;
      if (wr_cyc[0] != cmd_cyc + 1 || wr_cyc[3] != wr_cyc[0] + 3) begin
        fails++;
        $display("FAIL basic_timing: strobes at %0d..%0d, required %0d..%0d",
                 wr_cyc[0], wr_cyc[3], cmd_cyc + 1, cmd_cyc + 4);
      end
      tests++;
      if (done_cyc.size() == 1 && done_cyc[0] != wr_cyc[3]) begin
        fails++;
        $display("FAIL basic_done_cycle: done at %0d, required %0d", done_cyc[0], wr_cyc[3]);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      fails++;
      $display("FAIL basic_idle: cmd_ready/busy/done=%b required 100", {cmd_ready, busy, done});
    end
  endtask

  task automatic test_wrap();
    clear_mon();
    make_data(3);
    build_exp(3'd6, 10'd1022, 3);
    issue_cmd(3'd6, 10'd1022, 10'd3);
    drive_pixels(0, 3, 1'b1);
    wait_done("wrap");
    tests++;
    if (wr_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL wrap_count: got %0d writes, required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (wr_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL wrap_write[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_video_pause();
    logic [9:0] base;
    int c0;
    int bad = 0;
    clear_mon();
    base = 10'($urandom);
    make_data(5);
    build_exp(3'd1, base, 5);
    issue_cmd(3'd1, base, 10'd5);
    drive_pixels(0, 2, 1'b0);
    c0 = cyc;
    video_enable = 1'b1;
    pix_valid    = 1'b1;
    pix_data     = data_q[2];
    repeat (10) begin
      #1;
      if (pix_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    #1;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL pause_ready: pix_ready high in %0d of 10 cycles, required 0", bad);
    end
    tests++;
    if (wr_q.size() != 2) begin
      fails++;
      $display("FAIL pause_strobes: got %0d writes during pause, required 2", wr_q.size());
    end
    drive_pixels(2, 3, 1'b0);
    wait_done("pause");
    tests++;
    if (wr_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL pause_count: got %0d writes, required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (wr_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL pause_write[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
        end
      end
      tests++;
      if (wr_cyc[1] != c0 || wr_cyc[2] != c0 + 11) begin
        fails++;
        $display("FAIL pause_resume: strobes at %0d,%0d required %0d,%0d", wr_cyc[1], wr_cyc[2], c0, c0 + 11);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_length();
    clear_mon();
    issue_cmd(3'd4, 10'd77, 10'd0);
    #1;
    tests++;
    if ({done, mem_write_enable} !== 2'b10) begin
      fails++;
      $display("FAIL zero_done: done/we=%b required 10", {done, mem_write_enable});
    end
    pix_valid = 1'b1;
    repeat (4) @(negedge clk);
    pix_valid = 1'b0;
    tests++;
    if (wr_q.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != cmd_cyc) begin
      fails++;
      $display("FAIL zero_writes: got %0d writes %0d dones, required 0 writes 1 done", wr_q.size(), done_cyc.size());
    end
  endtask

  task automatic test_clamp();
    clear_mon();
    make_data(MAXW);
    build_exp(3'd7, 10'd900, 500);
    issue_cmd(3'd7, 10'd900, 10'd500);
    drive_pixels(0, MAXW, 1'b0);
    wait_done("clamp");
    pix_valid = 1'b1;
    pix_data  = 12'hABC;
    repeat (5) @(negedge clk);
    pix_valid = 1'b0;
    tests++;
    if (wr_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL clamp_count: got %0d writes, required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (wr_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL clamp_write[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    make_data(10);
    build_exp(3'd5, 10'd100, 10);
    issue_cmd(3'd5, 10'd100, 10'd10);
    drive_pixels(0, 3, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({cmd_ready, pix_ready, mem_write_enable, busy, done} !== 5'b0) begin
      fails++;
      $display("FAIL midreset_ctrl: got %b required 00000", {cmd_ready, pix_ready, mem_write_enable, busy, done});
    end
    tests++;
    if ({mem_element, mem_address, mem_datain} !== 25'b0) begin
      fails++;
      $display("FAIL midreset_mem: got %h required 0", {mem_element, mem_address, mem_datain});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_ready: cmd_ready=%b required 1", cmd_ready);
    end
    pix_valid = 1'b1;
    repeat (5) @(negedge clk);
    pix_valid = 1'b0;
    tests++;
    if (wr_q.size() != 3 || done_cyc.size() != 0) begin
      fails++;
      $display("FAIL midreset_count: got %0d writes %0d dones, required 3 and 0", wr_q.size(), done_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (wr_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL midreset_write[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_cmd_while_busy();
    clear_mon();
    make_data(6);
    build_exp(3'd3, 10'd512, 6);
    issue_cmd(3'd3, 10'd512, 10'd6);
    cmd_element = 3'd0;
    cmd_base    = 10'd5;
    cmd_length  = 10'd2;
    cmd_valid   = 1'b1;
    drive_pixels(0, 6, 1'b1);
    cmd_valid = 1'b0;
    wait_done("busycmd");
    repeat (4) @(negedge clk);
    tests++;
    if (wr_q.size() != exp_q.size() || busy !== 1'b0) begin
      fails++;
      $display("FAIL busycmd_count: got %0d writes busy=%b, required %0d busy=0", wr_q.size(), busy, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (wr_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL busycmd_write[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] el;
    logic [9:0] base;
    logic [9:0] len;
    int n;
    for (int k = 0; k < 8; k++) begin
      clear_mon();
      el   = 3'($urandom);
      base = 10'($urandom);
      len  = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(390, 1023)) : 10'($urandom_range(0, 40));
      n    = (int'(len) > MAXW) ? MAXW : int'(len);
      make_data(n);
      build_exp(el, base, int'(len));
      issue_cmd(el, base, len);
      drive_pixels(0, n, 1'b1);
      wait_done("random");
      repeat (2) @(negedge clk);
      tests++;
      if (wr_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL random%0d_count: got %0d writes, required %0d", k, wr_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          tests++;
          if (wr_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL random%0d_write[%0d]: got %h required %h", k, i, wr_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_video_pause();
    test_zero_length();
    test_clamp();
    test_reset_mid();
    test_cmd_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
